// File: rtl/delay_checker_pkg.sv
// Shared types and helpers for the delay_checker monitor and its shadow ring.
package delay_checker_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Pointer width for a ring of the given length; never narrower than one bit.
    function automatic int ptr_width(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/delay_checker_ring.sv
// Shadow ring mirroring the delay under test: read-before-write at wp on each enabled cycle.
module delay_checker_ring
    import delay_checker_pkg::*;
#(
    parameter int LENGTH = 10,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             flush,
    input  logic [WIDTH-1:0] stim,
    output logic [WIDTH-1:0] exp_val
);

    localparam int PTR_W = ptr_width(LENGTH);

    logic [WIDTH-1:0] ring [LENGTH];
    logic [PTR_W-1:0] wp;

    assign exp_val = ring[wp];

    // Flush only rewinds the pointer; stale contents are hidden by the fill phase.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
        end else if (ena) begin
            wp <= (wp == PTR_W'(LENGTH - 1)) ? '0 : wp + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && ena) begin
            ring[wp] <= stim;
        end
    end

endmodule

// File: rtl/delay_checker.sv
// Self-checking monitor for a delay line: shadow ring, fill/check/halt FSM,
// saturating compare and mismatch counters and a first-mismatch snapshot.
module delay_checker
    import delay_checker_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             flush,
    input  logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] dut_out,
    output logic             armed,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    localparam int FC_W = $clog2(LENGTH + 1);

    state_t           state, state_next;
    logic [FC_W-1:0]  fc;
    logic [WIDTH-1:0] exp_val;
    logic             flush_eff;
    logic             do_cmp;
    logic             mismatch;

    // A halted checker ignores flush, so the ring keeps advancing untouched.
    assign flush_eff = flush && (state != HALT);
    assign do_cmp    = (state == CHECK) && ena && !flush_eff;
    assign mismatch  = do_cmp && (dut_out != exp_val);

    delay_checker_ring #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .flush   (flush_eff),
        .stim    (stim),
        .exp_val (exp_val)
    );

    always_comb begin
        state_next = state;
        if (flush_eff) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (ena && (fc == FC_W'(LENGTH - 1))) state_next = CHECK;
                CHECK:   if (mismatch && STOP_ON_ERR) state_next = HALT;
                HALT:    state_next = HALT;
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            armed <= 1'b0;
            fc    <= '0;
        end else begin
            state <= state_next;
            armed <= (state_next == CHECK);
            if (flush_eff) begin
                fc <= '0;
            end else if ((state == FILL) && ena && (fc != FC_W'(LENGTH))) begin
                fc <= fc + FC_W'(1);
            end
        end
    end

    // The snapshot is taken only while err is still clear, i.e. once per reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err       <= 1'b0;
            err_cnt   <= '0;
            chk_cnt   <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else if (do_cmp) begin
            chk_cnt <= CNT_W'(sat_inc(32'(chk_cnt), CNT_W));
            if (mismatch) begin
                err     <= 1'b1;
                err_cnt <= CNT_W'(sat_inc(32'(err_cnt), CNT_W));
                if (!err) begin
                    first_exp <= exp_val;
                    first_got <= dut_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_checker.sv
// Bench for delay_checker: three configurations checked against a history-based model,
// a hand-computed vector table and directed corner-case sequences.
module tb_delay_checker;

    typedef struct packed {
        logic [15:0][7:0] hist;
        int               fill;
        bit               halted;
        int               chk;
        int               errc;
        bit               err;
        logic [7:0]       fexp;
        logic [7:0]       fgot;
    } model_t;

    typedef struct packed {
        logic       rst;
        logic       ena;
        logic       flush;
        logic [7:0] stim;
        logic [7:0] dout;
        logic       armed;
        logic       err;
        logic [3:0] ecnt;
        logic [3:0] ccnt;
        logic [7:0] fexp;
        logic [7:0] fgot;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v   = '0;
    logic [2:0] ena_v   = '0;
    logic [2:0] flush_v = '0;
    logic [7:0] stim_v [3];
    logic [7:0] dout_v [3];
    logic [2:0] armed_v;
    logic [2:0] err_v;
    logic [7:0] fexp_v [3];
    logic [7:0] fgot_v [3];
    logic [15:0] ecnt_a, ccnt_a;
    logic [3:0]  ecnt_s, ccnt_s;
    logic [7:0]  ecnt_h, ccnt_h;

    model_t mdl [3];
    int n_cmp  = 0;
    int n_fail = 0;

    delay_checker #(.LENGTH(10), .WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst(rst_v[0]), .ena(ena_v[0]), .flush(flush_v[0]),
        .stim(stim_v[0]), .dut_out(dout_v[0]), .armed(armed_v[0]), .err(err_v[0]),
        .err_cnt(ecnt_a), .chk_cnt(ccnt_a), .first_exp(fexp_v[0]), .first_got(fgot_v[0]));

    delay_checker #(.LENGTH(3), .WIDTH(8), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut_s (
        .clk(clk), .rst(rst_v[1]), .ena(ena_v[1]), .flush(flush_v[1]),
        .stim(stim_v[1]), .dut_out(dout_v[1]), .armed(armed_v[1]), .err(err_v[1]),
        .err_cnt(ecnt_s), .chk_cnt(ccnt_s), .first_exp(fexp_v[1]), .first_got(fgot_v[1]));

    delay_checker #(.LENGTH(4), .WIDTH(8), .CNT_W(8), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst(rst_v[2]), .ena(ena_v[2]), .flush(flush_v[2]),
        .stim(stim_v[2]), .dut_out(dout_v[2]), .armed(armed_v[2]), .err(err_v[2]),
        .err_cnt(ecnt_h), .chk_cnt(ccnt_h), .first_exp(fexp_v[2]), .first_got(fgot_v[2]));

    function automatic int len_of(input int k);
        case (k)
            0:       return 10;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int cw_of(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit stop_of(input int k);
        return k == 2;
    endfunction

    function automatic logic [31:0] act_ecnt(input int k);
        case (k)
            0:       return 32'(ecnt_a);
            1:       return 32'(ecnt_s);
            default: return 32'(ecnt_h);
        endcase
    endfunction

    function automatic logic [31:0] act_ccnt(input int k);
        case (k)
            0:       return 32'(ccnt_a);
            1:       return 32'(ccnt_s);
            default: return 32'(ccnt_h);
        endcase
    endfunction

    // Correct delay output: the value stored LENGTH enabled cycles ago.
    function automatic logic [7:0] golden(input int k);
        return mdl[k].hist[len_of(k) - 1];
    endfunction

    // Behaviour as seen from outside: compare only once LENGTH values are stored since the last restart.
    function automatic model_t model_step(input model_t m_in, input int k, input logic r, input logic e,
                                          input logic f, input logic [7:0] s, input logic [7:0] g);
        model_t     m;
        int         len;
        int         cmax;
        logic [7:0] ev;
        m    = m_in;
        len  = len_of(k);
        cmax = (1 << cw_of(k)) - 1;
        if (r) return '0;
        if (f && !m.halted) begin
            m.fill = 0;
            return m;
        end
        if (e) begin
            if (!m.halted && m.fill >= len) begin
                ev = m.hist[len - 1];
                if (m.chk < cmax) m.chk = m.chk + 1;
                if (g !== ev) begin
                    if (m.errc < cmax) m.errc = m.errc + 1;
                    if (!m.err) begin
                        m.fexp = ev;
                        m.fgot = g;
                    end
                    m.err = 1'b1;
                    if (stop_of(k)) m.halted = 1'b1;
                end
            end
            m.hist = {m.hist[14:0], s};
            if (m.fill < len) m.fill = m.fill + 1;
        end
        return m;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp = n_cmp + 1;
        if (act !== expv) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input int k, input bit r, input bit e, input bit f,
                                 input logic [7:0] s, input logic [7:0] d);
        @(negedge clk);
        rst_v     = '0;
        ena_v     = '0;
        flush_v   = '0;
        rst_v[k]   = r;
        ena_v[k]   = e;
        flush_v[k] = f;
        stim_v[k]  = s;
        dout_v[k]  = d;
        @(posedge clk);
        for (int kk = 0; kk < 3; kk++)
            mdl[kk] = model_step(mdl[kk], kk, rst_v[kk], ena_v[kk], flush_v[kk], stim_v[kk], dout_v[kk]);
        #1;
    endtask

    task automatic checkOutput(input int k, input string name);
        cmp({name, " armed"}, 32'(armed_v[k]), 32'(!mdl[k].halted && mdl[k].fill >= len_of(k)));
        cmp({name, " err"}, 32'(err_v[k]), 32'(mdl[k].err));
        cmp({name, " err_cnt"}, act_ecnt(k), 32'(mdl[k].errc));
        cmp({name, " chk_cnt"}, act_ccnt(k), 32'(mdl[k].chk));
        cmp({name, " first_exp"}, 32'(fexp_v[k]), 32'(mdl[k].fexp));
        cmp({name, " first_got"}, 32'(fgot_v[k]), 32'(mdl[k].fgot));
    endtask

    vec_t vecs [14];

    initial begin
        logic [7:0] s;
        logic [7:0] d;
        bit         r, e, f;

        for (int k = 0; k < 3; k++) begin
            stim_v[k] = '0;
            dout_v[k] = '0;
            mdl[k]    = '0;
        end

        //                rst  ena  flsh stim   dout   armd err  ecnt  ccnt  fexp   fgot
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h44, 8'h11, 1'b1, 1'b0, 4'd0, 4'd1, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h55, 8'h99, 1'b1, 1'b0, 4'd0, 4'd1, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h22, 1'b1, 1'b0, 4'd0, 4'd2, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h66, 8'h30, 1'b1, 1'b1, 4'd1, 4'd3, 8'h33, 8'h30};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h77, 8'h44, 1'b0, 1'b1, 4'd1, 4'd3, 8'h33, 8'h30};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, 4'd1, 4'd3, 8'h33, 8'h30};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h82, 8'h00, 1'b0, 1'b1, 4'd1, 4'd3, 8'h33, 8'h30};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h83, 8'h00, 1'b1, 1'b1, 4'd1, 4'd3, 8'h33, 8'h30};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h84, 8'h81, 1'b1, 1'b1, 4'd1, 4'd4, 8'h33, 8'h30};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h85, 8'h00, 1'b1, 1'b1, 4'd2, 4'd5, 8'h33, 8'h30};

        $display("[TB] vector table on LENGTH=3 instance");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, vecs[i].rst, vecs[i].ena, vecs[i].flush, vecs[i].stim, vecs[i].dout);
            cmp($sformatf("vec%0d armed", i), 32'(armed_v[1]), 32'(vecs[i].armed));
            cmp($sformatf("vec%0d err", i), 32'(err_v[1]), 32'(vecs[i].err));
            cmp($sformatf("vec%0d err_cnt", i), 32'(ecnt_s), 32'(vecs[i].ecnt));
            cmp($sformatf("vec%0d chk_cnt", i), 32'(ccnt_s), 32'(vecs[i].ccnt));
            cmp($sformatf("vec%0d first_exp", i), 32'(fexp_v[1]), 32'(vecs[i].fexp));
            cmp($sformatf("vec%0d first_got", i), 32'(fgot_v[1]), 32'(vecs[i].fgot));
            checkOutput(1, $sformatf("vec%0d model", i));
        end

        $display("[TB] clean stream, 1000 enabled cycles");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput(0, "reset A");
        cmp("reset A armed", 32'(armed_v[0]), 32'd0);
        for (int i = 1; i <= 1000; i++) begin
            s = 8'($urandom);
            applyStimulus(0, 1'b0, 1'b1, 1'b0, s, golden(0));
            checkOutput(0, "clean");
            if (i == 9)  cmp("armed before fill done", 32'(armed_v[0]), 32'd0);
            if (i == 10) cmp("armed after fill done", 32'(armed_v[0]), 32'd1);
        end
        cmp("clean chk_cnt", 32'(ccnt_a), 32'd990);
        cmp("clean err_cnt", 32'(ecnt_a), 32'd0);
        cmp("clean err", 32'(err_v[0]), 32'd0);

        $display("[TB] single-bit fault on expected 5A");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= 30; i++) begin
            s = (i == 12) ? 8'h5A : 8'($urandom);
            d = golden(0);
            if (i == 22) d = d ^ 8'h01;
            applyStimulus(0, 1'b0, 1'b1, 1'b0, s, d);
            checkOutput(0, "fault");
            if (i == 21) cmp("fault err before", 32'(err_v[0]), 32'd0);
            if (i == 22) begin
                cmp("fault err", 32'(err_v[0]), 32'd1);
                cmp("fault err_cnt", 32'(ecnt_a), 32'd1);
                cmp("fault first_exp", 32'(fexp_v[0]), 32'h5A);
                cmp("fault first_got", 32'(fgot_v[0]), 32'h5B);
            end
        end

        $display("[TB] ena toggling");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= 40; i++) begin
            e = (i % 2) == 1;
            applyStimulus(0, 1'b0, e, 1'b0, 8'($urandom), golden(0));
            checkOutput(0, "toggle");
            if (i == 18) cmp("toggle armed clk18", 32'(armed_v[0]), 32'd0);
            if (i == 19) cmp("toggle armed clk19", 32'(armed_v[0]), 32'd1);
        end
        cmp("toggle chk_cnt", 32'(ccnt_a), 32'd10);
        cmp("toggle err", 32'(err_v[0]), 32'd0);

        $display("[TB] flush mid-check");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= 40; i++) begin
            f = (i == 20);
            applyStimulus(0, 1'b0, 1'b1, f, 8'($urandom), golden(0));
            checkOutput(0, "flush");
            if (i == 20) begin
                cmp("flush armed drop", 32'(armed_v[0]), 32'd0);
                cmp("flush chk kept", 32'(ccnt_a), 32'd9);
            end
            if (i == 30) cmp("flush chk masked", 32'(ccnt_a), 32'd9);
        end
        cmp("flush chk_cnt end", 32'(ccnt_a), 32'd19);
        cmp("flush err", 32'(err_v[0]), 32'd0);

        $display("[TB] stop-on-error with stuck bit 7");
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(2, 1'b0, 1'b1, 1'b0, 8'hFF, golden(2) & 8'h7F);
            checkOutput(2, "halt");
        end
        cmp("halt err_cnt", 32'(ecnt_h), 32'd1);
        cmp("halt chk_cnt", 32'(ccnt_h), 32'd1);
        cmp("halt armed", 32'(armed_v[2]), 32'd0);
        cmp("halt first_exp", 32'(fexp_v[2]), 32'hFF);
        cmp("halt first_got", 32'(fgot_v[2]), 32'h7F);
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h7F);
        checkOutput(2, "halt flush");
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput(2, "halt reset");
        cmp("halt reset err", 32'(err_v[2]), 32'd0);
        cmp("halt reset err_cnt", 32'(ecnt_h), 32'd0);
        cmp("halt reset first_exp", 32'(fexp_v[2]), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(2, 1'b0, 1'b1, 1'b0, 8'hFF, golden(2));
            checkOutput(2, "refill");
        end
        cmp("refill armed", 32'(armed_v[2]), 32'd1);
        cmp("refill chk_cnt", 32'(ccnt_h), 32'd1);

        $display("[TB] counter saturation");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= 25; i++) begin
            applyStimulus(1, 1'b0, 1'b1, 1'b0, 8'($urandom), golden(1) ^ 8'h01);
            checkOutput(1, "sat");
        end
        cmp("sat err_cnt", 32'(ecnt_s), 32'd15);
        cmp("sat chk_cnt", 32'(ccnt_s), 32'd15);

        $display("[TB] randomized traffic");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= 2000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 49) == 0);
            d = golden(0);
            if ($urandom_range(0, 19) == 0) d = d ^ 8'(1 << $urandom_range(0, 7));
            applyStimulus(0, r, e, f, 8'($urandom), d);
            checkOutput(0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
